fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-domain control block of the asynchronous FIFO. It owns the write pointer, kept in binary and Gray code, and produces the RAM write address and write strobe. It also brings the read domain's Gray-coded read pointer into the write clock domain and generates the registered full, almost-full, fill-level and sticky overflow flags. It is the write-side counterpart of the read domain's empty detection and pairs with it through the Gray pointer crossing.

## Interface
- ADDR_WIDTH, 4, number of RAM address bits; depth = 2**ADDR_WIDTH; must be >= 2
- AFULL_THRESH, 12, almost-full level; range 1..2**ADDR_WIDTH
- SYNC_STAGES, 2, flop stages in the read-pointer synchronizer; must be >= 2

- wr_clk  input  1  write-domain clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request, sampled on the rising edge of wr_clk
- rd_ptr_gray  input  ADDR_WIDTH+1  Gray-coded read pointer, asynchronous to wr_clk
- ovf_clr  input  1  clears wr_overflow
- wr_inc  output  1  RAM write strobe, combinational: wr_en & ~wr_full
- wr_addr  output  ADDR_WIDTH  RAM write address: the low bits of the binary write pointer
- wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain
- wr_full  output  1  registered full flag
- wr_almost_full  output  1  registered flag: level >= AFULL_THRESH
- wr_level  output  ADDR_WIDTH+1  registered fill level as seen from the write domain, 0..2**ADDR_WIDTH
- wr_overflow  output  1  sticky flag: a write was attempted while full

## Operation
- Pointers are ADDR_WIDTH+1 bits wide. The extra MSB is the wrap bit.
- The binary write pointer wbin advances by 1 when wr_inc = 1. Its next value is wbin_nxt.
- wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1).
- wr_ptr_gray is registered directly from wgray_nxt. It is never derived combinationally from the binary pointer, so it changes by at most one bit per edge.
- rd_ptr_gray passes through SYNC_STAGES flops, which reset to 0. The result is rq_sync.
- rbin_sync = Gray-to-binary conversion of rq_sync.
- Full condition: wgray_nxt == {~rq_sync[A:A-1], rq_sync[A-2:0]}, where A = ADDR_WIDTH.
- wr_full is registered from the full condition.
- Level: level_nxt = (wbin_nxt - rbin_sync) mod 2**(A+1). wr_level is registered from level_nxt.
- wr_almost_full is registered from (level_nxt >= AFULL_THRESH).
- Overflow: wr_overflow is set when wr_en & wr_full and cleared when ovf_clr is high. If both happen in the same cycle, set wins.
- Write while full: the write is dropped. wr_inc = 0, and the pointers and wr_addr hold.
- The level is pessimistic: it includes reads that have not yet synchronized. It therefore never under-reports occupancy.
- Wrap-around: the pointers wrap modulo 2**(A+1) with no special case. Full and level remain correct across the wrap.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - wbin, wr_ptr_gray and wr_addr = 0
  - synchronizer flops = 0
  - wr_full, wr_almost_full and wr_overflow = 0
  - wr_level = 0
- Reset asserted mid-operation returns the block to the reset values above regardless of pending writes. The read domain must be reset concurrently.
- Accepted write: wr_inc is high during the cycle in which wr_en = 1 and wr_full = 0. The RAM writes at wr_addr on that edge. wr_addr, wr_ptr_gray, wr_level and wr_full reflect the write immediately after the same edge.
- Full asserts on the edge of the write that fills the FIFO: zero cycles of slack, so no write beyond the last free slot is ever accepted.
- Read-pointer latency: a change of rd_ptr_gray before edge k appears in rq_sync after edge k+SYNC_STAGES-1. wr_full, wr_level and wr_almost_full reflect it after edge k+SYNC_STAGES.
- A simultaneous write and synchronized read leave wr_level unchanged.

## Structure
- Shared package: the default values of ADDR_WIDTH, SYNC_STAGES and AFULL_THRESH, and the gray2bin/bin2gray functions shared with the read-domain blocks.
- One sub-module: ptr_sync, a parameterized SYNC_STAGES-deep multi-bit flop synchronizer with asynchronous reset. The same module is reused by the read domain for the write pointer.

## Test plan
- Reset, then idle with rd_ptr_gray = 0: all outputs are 0 and wr_addr = 0. Pulsing ovf_clr has no effect.
- 16 back-to-back writes with the read pointer held at 0:
  - wr_almost_full rises after the 12th edge.
  - wr_full rises after the 16th edge.
  - wr_level = 16.
  - wr_ptr_gray = 0x18.
- FIFO full, wr_en held for 3 cycles:
  - wr_inc = 0 and the pointer is unchanged.
  - wr_overflow = 1 and stays high.
  - wr_overflow clears on ovf_clr only after wr_en drops.
  - ovf_clr together with wr_en while full leaves wr_overflow at 1.
- FIFO full, rd_ptr_gray driven to 0x01 before edge k: wr_full falls and wr_level becomes 15 after edge k+2.
- 40 writes, with rd_ptr_gray tracking the write pointer 4 entries behind (binary), applied as Gray:
  - Each edge changes at most one bit of wr_ptr_gray.
  - The final wr_ptr_gray = 0x0C and wr_addr = 8.
  - wr_full never asserts.
- Async rst_n pulsed low mid-edge during a write burst: outputs return to reset values immediately, without waiting for a clock edge, and the first write after release uses wr_addr = 0.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and the
// Gray/binary conversions used by both the write and read domain blocks.
package fifo_wr_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_AFULL_THRESH = 12;

  // Conversions work on a fixed wide word; callers zero-extend and truncate.
  localparam int MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// Multi-bit flop synchronizer for Gray-coded pointers crossing clock domains.
// Only safe for values that change by at most one bit per source edge.
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain control of the asynchronous FIFO: write pointer (binary and
// Gray), RAM write strobe/address, synchronized read pointer and write flags.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  input  logic                  ovf_clr,
  output logic                  wr_inc,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int A  = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_gray;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q,  full_d;
  logic          afull_q, afull_d;
  logic          ovf_q,   ovf_d;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rq_sync)
  );

  // A write attempted while full is dropped; the pointer simply holds.
  assign wr_inc = wr_en & ~full_q;

  always_comb begin
    rbin_sync = PW'(gray2bin(MAX_PTR_W'(rq_sync)));
    // Full when the next write pointer is one lap ahead of the read pointer,
    // which in Gray code means the top two bits differ and the rest match.
    full_gray = {~rq_sync[A:A-1], rq_sync[A-2:0]};
    wbin_d    = wbin_q + PW'(wr_inc);
    wgray_d   = PW'(bin2gray(MAX_PTR_W'(wbin_d)));
    full_d    = (wgray_d == full_gray);
    level_d   = wbin_d - rbin_sync;
    afull_d   = (level_d >= PW'(AFULL_THRESH));
    ovf_d     = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr        = wbin_q[A-1:0];
  assign wr_ptr_gray    = wgray_q;
  assign wr_full        = full_q;
  assign wr_almost_full = afull_q;
  assign wr_level       = level_q;
  assign wr_overflow    = ovf_q;

endmodule
